// File: rtl/hpdcache_refill_ctrl.sv
// Refill controller: gathers memory response flits into a cache line, retires the MSHR entry,
// writes the line and optionally answers the core. Define HPDCACHE_REFILL_PERF_EN for perf counters.
module hpdcache_refill_ctrl #(
  parameter int MSHR_SET_W = 2,
  parameter int MSHR_WAY_W = 1,
  parameter int MEM_DATA_W = 64,
  parameter int LINE_W     = 512,
  parameter int SET_W      = 7,
  parameter int TAG_W      = 20,
  parameter int WAY_W      = 2,
  parameter int TID_W      = 6,
  parameter int SID_W      = 3,
  parameter int WORD_W     = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             mem_rsp_valid_i,
  output logic                             mem_rsp_ready_o,
  input  logic [MEM_DATA_W-1:0]            mem_rsp_data_i,
  input  logic [MSHR_WAY_W+MSHR_SET_W-1:0] mem_rsp_id_i,
  input  logic                             mem_rsp_last_i,
  input  logic                             mem_rsp_error_i,
  output logic                             ack_req_o,
  input  logic                             ack_gnt_i,
  output logic                             mshr_ack_o,
  output logic                             mshr_ack_cs_o,
  output logic [MSHR_SET_W-1:0]            mshr_ack_set_o,
  output logic [MSHR_WAY_W-1:0]            mshr_ack_way_o,
  input  logic [TID_W-1:0]                 mshr_req_id_i,
  input  logic [SID_W-1:0]                 mshr_src_id_i,
  input  logic [SET_W-1:0]                 mshr_cache_set_i,
  input  logic [WAY_W-1:0]                 mshr_cache_way_i,
  input  logic [TAG_W-1:0]                 mshr_cache_tag_i,
  input  logic [WORD_W-1:0]                mshr_word_i,
  input  logic                             mshr_need_rsp_i,
  output logic                             refill_valid_o,
  input  logic                             refill_ready_i,
  output logic [SET_W-1:0]                 refill_set_o,
  output logic [WAY_W-1:0]                 refill_way_o,
  output logic [TAG_W-1:0]                 refill_tag_o,
  output logic [LINE_W-1:0]                refill_data_o,
  output logic                             core_rsp_valid_o,
  input  logic                             core_rsp_ready_i,
  output logic [TID_W-1:0]                 core_rsp_tid_o,
  output logic [SID_W-1:0]                 core_rsp_sid_o,
  output logic [MEM_DATA_W-1:0]            core_rsp_data_o,
  output logic                             core_rsp_error_o,
  output logic                             busy_o
`ifdef HPDCACHE_REFILL_PERF_EN
  ,
  output logic [31:0]                      perf_refill_cnt_o,
  output logic [31:0]                      perf_err_cnt_o
`endif
);

  localparam int FLITS = LINE_W / MEM_DATA_W;
  localparam int CNT_W = WORD_W + 1;
  localparam int ID_W  = MSHR_WAY_W + MSHR_SET_W;

  typedef enum logic [2:0] {IDLE, RECV, ACK_REQ, ACK_RD, WRITE, RSP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [TID_W-1:0]    req_id_q, req_id_d;
  logic [SID_W-1:0]    src_id_q, src_id_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                need_rsp_q, need_rsp_d;
  logic                accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      id_q       <= '0;
      line_q     <= '0;
      req_id_q   <= '0;
      src_id_q   <= '0;
      set_q      <= '0;
      way_q      <= '0;
      tag_q      <= '0;
      word_q     <= '0;
      need_rsp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      id_q       <= id_d;
      line_q     <= line_d;
      req_id_q   <= req_id_d;
      src_id_q   <= src_id_d;
      set_q      <= set_d;
      way_q      <= way_d;
      tag_q      <= tag_d;
      word_q     <= word_d;
      need_rsp_q <= need_rsp_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    id_d            = id_q;
    line_d          = line_q;
    req_id_d        = req_id_q;
    src_id_d        = src_id_q;
    set_d           = set_q;
    way_d           = way_q;
    tag_d           = tag_q;
    word_d          = word_q;
    need_rsp_d      = need_rsp_q;
    mem_rsp_ready_o = (state_q == IDLE) || (state_q == RECV);
    ack_req_o       = 1'b0;
    mshr_ack_o      = 1'b0;
    mshr_ack_cs_o   = 1'b0;
    refill_valid_o  = 1'b0;
    core_rsp_valid_o = 1'b0;
    accept          = mem_rsp_valid_i & mem_rsp_ready_o;

    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d = mem_rsp_id_i;
          line_d[MEM_DATA_W-1:0] = mem_rsp_data_i;
          cnt_d = CNT_W'(1);
          // a single-flit burst can only be a short line
          err_d = mem_rsp_error_i | (mem_rsp_last_i & (FLITS != 1));
          state_d = mem_rsp_last_i ? ACK_REQ : RECV;
        end
      end
      RECV: begin
        if (accept) begin
          if (cnt_q == CNT_W'(FLITS)) begin
            err_d = 1'b1;
          end else begin
            for (int k = 0; k < FLITS; k++) begin
              if (cnt_q == CNT_W'(k)) line_d[k*MEM_DATA_W +: MEM_DATA_W] = mem_rsp_data_i;
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (mem_rsp_error_i) err_d = 1'b1;
          if (mem_rsp_last_i) begin
            state_d = ACK_REQ;
            if (cnt_q != CNT_W'(FLITS - 1)) err_d = 1'b1;
          end
        end
      end
      ACK_REQ: begin
        ack_req_o     = 1'b1;
        mshr_ack_o    = ack_gnt_i;
        mshr_ack_cs_o = ack_gnt_i;
        if (ack_gnt_i) state_d = ACK_RD;
      end
      ACK_RD: begin
        req_id_d   = mshr_req_id_i;
        src_id_d   = mshr_src_id_i;
        set_d      = mshr_cache_set_i;
        way_d      = mshr_cache_way_i;
        tag_d      = mshr_cache_tag_i;
        word_d     = mshr_word_i;
        need_rsp_d = mshr_need_rsp_i;
        if (!err_q)               state_d = WRITE;
        else if (mshr_need_rsp_i) state_d = RSP;
        else                      state_d = IDLE;
      end
      WRITE: begin
        refill_valid_o = 1'b1;
        if (refill_ready_i) state_d = need_rsp_q ? RSP : IDLE;
      end
      RSP: begin
        core_rsp_valid_o = 1'b1;
        if (core_rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_rsp_data_o = '0;
    if (!err_q) begin
      for (int k = 0; k < FLITS; k++) begin
        if (word_q == WORD_W'(k)) core_rsp_data_o = line_q[k*MEM_DATA_W +: MEM_DATA_W];
      end
    end
  end

  assign mshr_ack_set_o   = id_q[MSHR_SET_W-1:0];
  assign mshr_ack_way_o   = id_q[ID_W-1:MSHR_SET_W];
  assign refill_set_o     = set_q;
  assign refill_way_o     = way_q;
  assign refill_tag_o     = tag_q;
  assign refill_data_o    = line_q;
  assign core_rsp_tid_o   = req_id_q;
  assign core_rsp_sid_o   = src_id_q;
  assign core_rsp_error_o = err_q;
  assign busy_o           = (state_q != IDLE);

`ifdef HPDCACHE_REFILL_PERF_EN
  logic [31:0] perf_refill_cnt_q, perf_refill_cnt_d;
  logic [31:0] perf_err_cnt_q, perf_err_cnt_d;

  always_comb begin
    perf_refill_cnt_d = perf_refill_cnt_q;
    perf_err_cnt_d    = perf_err_cnt_q;
    if (state_q == WRITE && refill_ready_i) perf_refill_cnt_d = perf_refill_cnt_q + 32'd1;
    if (state_q == ACK_RD && err_q)         perf_err_cnt_d    = perf_err_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_refill_cnt_q <= '0;
      perf_err_cnt_q    <= '0;
    end else begin
      perf_refill_cnt_q <= perf_refill_cnt_d;
      perf_err_cnt_q    <= perf_err_cnt_d;
    end
  end

  assign perf_refill_cnt_o = perf_refill_cnt_q;
  assign perf_err_cnt_o    = perf_err_cnt_q;
`endif

endmodule

// File: tb/tb_hpdcache_refill_ctrl.sv
// Scoreboard bench for hpdcache_refill_ctrl: a transaction-level model queues the expected
// ack/refill/core responses and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_hpdcache_refill_ctrl;

  localparam int MSHR_SET_W = 2;
  localparam int MSHR_WAY_W = 1;
  localparam int MEM_DATA_W = 64;
  localparam int LINE_W     = 512;
  localparam int SET_W      = 7;
  localparam int TAG_W      = 20;
  localparam int WAY_W      = 2;
  localparam int TID_W      = 6;
  localparam int SID_W      = 3;
  localparam int WORD_W     = 3;
  localparam int FLITS      = 8;
  localparam int ID_W       = MSHR_WAY_W + MSHR_SET_W;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  mem_rsp_valid_i;
  logic                  mem_rsp_ready_o;
  logic [MEM_DATA_W-1:0] mem_rsp_data_i;
  logic [ID_W-1:0]       mem_rsp_id_i;
  logic                  mem_rsp_last_i;
  logic                  mem_rsp_error_i;
  logic                  ack_req_o;
  logic                  ack_gnt_i;
  logic                  mshr_ack_o;
  logic                  mshr_ack_cs_o;
  logic [MSHR_SET_W-1:0] mshr_ack_set_o;
  logic [MSHR_WAY_W-1:0] mshr_ack_way_o;
  logic [TID_W-1:0]      mshr_req_id_i;
  logic [SID_W-1:0]      mshr_src_id_i;
  logic [SET_W-1:0]      mshr_cache_set_i;
  logic [WAY_W-1:0]      mshr_cache_way_i;
  logic [TAG_W-1:0]      mshr_cache_tag_i;
  logic [WORD_W-1:0]     mshr_word_i;
  logic                  mshr_need_rsp_i;
  logic                  refill_valid_o;
  logic                  refill_ready_i;
  logic [SET_W-1:0]      refill_set_o;
  logic [WAY_W-1:0]      refill_way_o;
  logic [TAG_W-1:0]      refill_tag_o;
  logic [LINE_W-1:0]     refill_data_o;
  logic                  core_rsp_valid_o;
  logic                  core_rsp_ready_i;
  logic [TID_W-1:0]      core_rsp_tid_o;
  logic [SID_W-1:0]      core_rsp_sid_o;
  logic [MEM_DATA_W-1:0] core_rsp_data_o;
  logic                  core_rsp_error_o;
  logic                  busy_o;
`ifdef HPDCACHE_REFILL_PERF_EN
  logic [31:0]           perf_refill_cnt_o;
  logic [31:0]           perf_err_cnt_o;
`endif

  hpdcache_refill_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_id_i(mem_rsp_id_i),
    .mem_rsp_last_i(mem_rsp_last_i), .mem_rsp_error_i(mem_rsp_error_i),
    .ack_req_o(ack_req_o), .ack_gnt_i(ack_gnt_i),
    .mshr_ack_o(mshr_ack_o), .mshr_ack_cs_o(mshr_ack_cs_o),
    .mshr_ack_set_o(mshr_ack_set_o), .mshr_ack_way_o(mshr_ack_way_o),
    .mshr_req_id_i(mshr_req_id_i), .mshr_src_id_i(mshr_src_id_i),
    .mshr_cache_set_i(mshr_cache_set_i), .mshr_cache_way_i(mshr_cache_way_i),
    .mshr_cache_tag_i(mshr_cache_tag_i), .mshr_word_i(mshr_word_i),
    .mshr_need_rsp_i(mshr_need_rsp_i),
    .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_set_o(refill_set_o), .refill_way_o(refill_way_o),
    .refill_tag_o(refill_tag_o), .refill_data_o(refill_data_o),
    .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_ready_i(core_rsp_ready_i),
    .core_rsp_tid_o(core_rsp_tid_o), .core_rsp_sid_o(core_rsp_sid_o),
    .core_rsp_data_o(core_rsp_data_o), .core_rsp_error_o(core_rsp_error_o),
    .busy_o(busy_o)
`ifdef HPDCACHE_REFILL_PERF_EN
    , .perf_refill_cnt_o(perf_refill_cnt_o), .perf_err_cnt_o(perf_err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TID_W-1:0]  req_id;
    logic [SID_W-1:0]  src_id;
    logic [SET_W-1:0]  cset;
    logic [WAY_W-1:0]  cway;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] word;
    logic              need_rsp;
  } mshr_ent_t;

  typedef struct {
    logic [MSHR_SET_W-1:0] set;
    logic [MSHR_WAY_W-1:0] way;
  } ack_t;

  typedef struct {
    logic [SET_W-1:0]  set;
    logic [WAY_W-1:0]  way;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
    logic              need_rsp;
  } refill_t;

  typedef struct {
    logic [TID_W-1:0]      tid;
    logic [SID_W-1:0]      sid;
    logic [MEM_DATA_W-1:0] data;
    logic                  error;
  } rsp_t;

  mshr_ent_t tab [1 << ID_W];
  ack_t      ack_q[$];
  refill_t   refill_q[$];
  rsp_t      rsp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_refill_cnt = 0;
  int exp_err_cnt = 0;
  bit bp_mode = 1'b0;
  bit gnt_block = 1'b0;
  bit lat_on = 1'b0;

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // MSHR readback model plus ready/grant drivers; fields are garbage except the cycle after an ack
  initial begin
    logic          rd_pending;
    logic [ID_W-1:0] rd_id;
    ack_gnt_i = 1'b1; refill_ready_i = 1'b1; core_rsp_ready_i = 1'b1;
    mshr_req_id_i = '0; mshr_src_id_i = '0; mshr_cache_set_i = '0; mshr_cache_way_i = '0;
    mshr_cache_tag_i = '0; mshr_word_i = '0; mshr_need_rsp_i = 1'b0;
    forever begin
      @(negedge clk);
      rd_pending = mshr_ack_cs_o;
      rd_id = {mshr_ack_way_o, mshr_ack_set_o};
      @(posedge clk); #1;
      if (rd_pending) begin
        mshr_req_id_i    = tab[rd_id].req_id;
        mshr_src_id_i    = tab[rd_id].src_id;
        mshr_cache_set_i = tab[rd_id].cset;
        mshr_cache_way_i = tab[rd_id].cway;
        mshr_cache_tag_i = tab[rd_id].tag;
        mshr_word_i      = tab[rd_id].word;
        mshr_need_rsp_i  = tab[rd_id].need_rsp;
      end else begin
        mshr_req_id_i    = TID_W'($urandom);
        mshr_src_id_i    = SID_W'($urandom);
        mshr_cache_set_i = SET_W'($urandom);
        mshr_cache_way_i = WAY_W'($urandom);
        mshr_cache_tag_i = TAG_W'($urandom);
        mshr_word_i      = WORD_W'($urandom);
        mshr_need_rsp_i  = 1'($urandom);
      end
      ack_gnt_i        = gnt_block ? 1'b0 : (bp_mode ? 1'($urandom) : 1'b1);
      refill_ready_i   = bp_mode ? 1'($urandom) : 1'b1;
      core_rsp_ready_i = bp_mode ? 1'($urandom) : 1'b1;
    end
  end

  // monitor: pops expectations on every handshake
  initial begin
    int last_cyc = 0;
    int after = 0;
    bit prev_rv = 1'b0;
    bit prev_cv = 1'b0;
    ack_t a; refill_t r; rsp_t c;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (after == 1) begin
          checkOutput("idle_after_prefetch_busy", busy_o, 0);
          checkOutput("idle_after_prefetch_core_valid", core_rsp_valid_o, 0);
        end else if (after == 2) begin
          checkOutput("rsp_after_refill", core_rsp_valid_o, 1);
        end
        after = 0;
        if (mem_rsp_valid_i && mem_rsp_ready_o && mem_rsp_last_i) last_cyc = cyc;
        if (ack_req_o) checkOutput("mem_ready_blocked", mem_rsp_ready_o, 0);
        if (ack_req_o) checkOutput("ack_follows_gnt", mshr_ack_o, ack_gnt_i);
        if (mshr_ack_o) begin
          checkOutput("ack_cs", mshr_ack_cs_o, 1);
          if (lat_on) checkOutput("ack_latency", 32'(cyc - last_cyc), 1);
          if (ack_q.size() == 0) checkOutput("ack_unexpected", 1, 0);
          else begin
            a = ack_q.pop_front();
            checkOutput("ack_set", mshr_ack_set_o, a.set);
            checkOutput("ack_way", mshr_ack_way_o, a.way);
          end
        end
        if (refill_valid_o && !prev_rv && lat_on) checkOutput("refill_latency", 32'(cyc - last_cyc), 3);
        if (core_rsp_valid_o && !prev_cv && lat_on) checkOutput("core_latency", 32'(cyc - last_cyc), 4);
        if (refill_valid_o && refill_ready_i) begin
          if (refill_q.size() == 0) checkOutput("refill_unexpected", 1, 0);
          else begin
            r = refill_q.pop_front();
            checkOutput("refill_set", refill_set_o, r.set);
            checkOutput("refill_way", refill_way_o, r.way);
            checkOutput("refill_tag", refill_tag_o, r.tag);
            checkOutput("refill_data", refill_data_o, r.line);
            after = r.need_rsp ? 2 : 1;
          end
        end
        if (core_rsp_valid_o && core_rsp_ready_i) begin
          if (rsp_q.size() == 0) checkOutput("core_unexpected", 1, 0);
          else begin
            c = rsp_q.pop_front();
            checkOutput("core_tid", core_rsp_tid_o, c.tid);
            checkOutput("core_sid", core_rsp_sid_o, c.sid);
            checkOutput("core_data", core_rsp_data_o, c.data);
            checkOutput("core_error", core_rsp_error_o, c.error);
          end
        end
      end
      prev_rv = refill_valid_o;
      prev_cv = core_rsp_valid_o;
    end
  end

  task automatic waitIdle(input string name);
    int t = 0;
    @(negedge clk);
    while (busy_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (busy_o) checkOutput(name, 1, 0);
  endtask

  task automatic sendFlits(input logic [ID_W-1:0] id, input int nflits, input int err_idx,
                           input logic [MEM_DATA_W-1:0] flits [16], input bit with_last);
    int t;
    @(posedge clk); #1;
    for (int k = 0; k < nflits; k++) begin
      if (bp_mode && ($urandom % 3 == 0)) begin
        mem_rsp_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      mem_rsp_valid_i = 1'b1;
      mem_rsp_id_i    = id;
      mem_rsp_data_i  = flits[k];
      mem_rsp_last_i  = with_last && (k == nflits - 1);
      mem_rsp_error_i = (k == err_idx);
      t = 0;
      @(negedge clk);
      while (!mem_rsp_ready_o && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (!mem_rsp_ready_o) checkOutput("flit_accept_timeout", 1, 0);
      @(posedge clk); #1;
    end
    mem_rsp_valid_i = 1'b0;
    mem_rsp_last_i  = 1'b0;
    mem_rsp_error_i = 1'b0;
  endtask

  // one complete refill: program the MSHR entry, queue the expected responses, send flits
  task automatic applyStimulus(input logic [ID_W-1:0] id, input int nflits, input int err_idx,
                               input bit need_rsp, input logic [WORD_W-1:0] word,
                               input logic [MEM_DATA_W-1:0] base);
    logic [MEM_DATA_W-1:0] flits [16];
    logic [LINE_W-1:0] line;
    mshr_ent_t e;
    bit err;
    waitIdle("idle_timeout_before_txn");
    for (int k = 0; k < 16; k++)
      flits[k] = (base != 0) ? base + MEM_DATA_W'(k) : {$urandom, $urandom};
    line = '0;
    for (int k = 0; k < FLITS && k < nflits; k++) line[k*MEM_DATA_W +: MEM_DATA_W] = flits[k];
    e.req_id = TID_W'($urandom); e.src_id = SID_W'($urandom);
    e.cset = SET_W'($urandom); e.cway = WAY_W'($urandom); e.tag = TAG_W'($urandom);
    e.word = word; e.need_rsp = need_rsp;
    tab[id] = e;
    err = (err_idx >= 0 && err_idx < nflits) || (nflits != FLITS);
    ack_q.push_back('{set: id[MSHR_SET_W-1:0], way: id[ID_W-1:MSHR_SET_W]});
    if (!err) begin
      refill_q.push_back('{set: e.cset, way: e.cway, tag: e.tag, line: line, need_rsp: need_rsp});
      exp_refill_cnt++;
    end else begin
      exp_err_cnt++;
    end
    if (need_rsp)
      rsp_q.push_back('{tid: e.req_id, sid: e.src_id,
                        data: err ? '0 : flits[word], error: err});
    sendFlits(id, nflits, err_idx, flits, 1'b1);
  endtask

  initial begin
    logic [MEM_DATA_W-1:0] junk [16];
    int t;
    rst_i = 1'b1;
    mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0; mem_rsp_id_i = '0;
    mem_rsp_last_i = 1'b0; mem_rsp_error_i = 1'b0;
    for (int k = 0; k < (1 << ID_W); k++) tab[k] = '{default: '0};
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checkOutput("reset_mem_ready", mem_rsp_ready_o, 1);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_ack_req", ack_req_o, 0);
    checkOutput("reset_refill_valid", refill_valid_o, 0);
    checkOutput("reset_core_valid", core_rsp_valid_o, 0);
    checkOutput("reset_refill_data", refill_data_o, 0);
    checkOutput("reset_core_data", core_rsp_data_o, 0);

    $display("[TB] directed: full line id {1,2}, word 3");
    lat_on = 1'b1;
    applyStimulus(3'b110, 8, -1, 1'b1, 3'd3, 64'h10);
    waitIdle("idle_timeout_txn1");
    lat_on = 1'b0;

    $display("[TB] directed: prefetch refill");
    applyStimulus(3'b001, 8, -1, 1'b0, 3'd5, 64'h100);

    $display("[TB] directed: grant withheld");
    waitIdle("idle_timeout_gnt");
    gnt_block = 1'b1;
    applyStimulus(3'b010, 8, -1, 1'b1, 3'd7, 64'h200);
    t = 0;
    while (!ack_req_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput("gnt_hold_ack_req", ack_req_o, 1);
      checkOutput("gnt_hold_ack", mshr_ack_o, 0);
      checkOutput("gnt_hold_mem_ready", mem_rsp_ready_o, 0);
      @(negedge clk);
    end
    gnt_block = 1'b0;

    $display("[TB] directed: error flit, short line, overrun");
    applyStimulus(3'b011, 8, 4, 1'b1, 3'd4, 64'h300);
    applyStimulus(3'b100, 5, -1, 1'b1, 3'd1, 64'h400);
    applyStimulus(3'b101, 9, -1, 1'b1, 3'd2, 64'h500);

    $display("[TB] directed: reset during receive");
    waitIdle("idle_timeout_rst");
    for (int k = 0; k < 16; k++) junk[k] = 64'hdead0000 + 64'(k);
    sendFlits(3'b111, 4, -1, junk, 1'b0);
    rst_i = 1'b1;
    exp_refill_cnt = 0;
    exp_err_cnt = 0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", busy_o, 0);
    checkOutput("midrst_mem_ready", mem_rsp_ready_o, 1);
    applyStimulus(3'b111, 8, -1, 1'b1, 3'd6, 64'h600);

    $display("[TB] random phase");
    bp_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int r, nf, ei;
      r = $urandom % 6;
      nf = (r < 4) ? 8 : (r == 4) ? $urandom_range(2, 7) : 9;
      ei = ($urandom % 4 == 0) ? $urandom_range(0, nf - 1) : -1;
      applyStimulus(ID_W'($urandom), nf, ei, 1'($urandom), WORD_W'($urandom), '0);
    end
    waitIdle("idle_timeout_final");
    bp_mode = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("ack_queue_drained", 32'(ack_q.size()), 0);
    checkOutput("refill_queue_drained", 32'(refill_q.size()), 0);
    checkOutput("rsp_queue_drained", 32'(rsp_q.size()), 0);
`ifdef HPDCACHE_REFILL_PERF_EN
    checkOutput("perf_refill_cnt", perf_refill_cnt_o, 32'(exp_refill_cnt));
    checkOutput("perf_err_cnt", perf_err_cnt_o, 32'(exp_err_cnt));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hpdcache_refill_ctrl.md
Name: hpdcache_refill_ctrl

Overview:
- Downstream consumer of the MSHR's acknowledge interface.
- Collects multi-flit memory read responses for one miss into a full cache line.
- Retires the matching MSHR entry via ack/ack_cs, then reads back the entry fields one cycle later.
- Issues the line write into the cache data/directory, then optionally returns the requested word to the core.

Parameters:
MSHR_SET_W, 2, MSHR set index width
MSHR_WAY_W, 1, MSHR way index width
MEM_DATA_W, 64, memory response flit width (equals one core word)
LINE_W, 512, cache line width; FLITS = LINE_W/MEM_DATA_W (8)
SET_W, 7, cache set index width
TAG_W, 20, cache tag width
WAY_W, 2, cache way index width
TID_W, 6, core transaction id width
SID_W, 3, core source id width
WORD_W, 3, word-in-line index width (log2 FLITS)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mem_rsp_valid_i  in  1  response flit valid
mem_rsp_ready_o  out  1  response flit accepted
mem_rsp_data_i  in  MEM_DATA_W  flit data
mem_rsp_id_i  in  MSHR_WAY_W+MSHR_SET_W  {mshr_way, mshr_set}
mem_rsp_last_i  in  1  last flit of line
mem_rsp_error_i  in  1  flit carries bus error
ack_req_o  out  1  request for MSHR ack slot
ack_gnt_i  in  1  arbiter grant (no alloc/check this cycle)
mshr_ack_o  out  1  MSHR ack
mshr_ack_cs_o  out  1  MSHR RAM chip select
mshr_ack_set_o  out  MSHR_SET_W  MSHR set
mshr_ack_way_o  out  MSHR_WAY_W  MSHR way
mshr_req_id_i  in  TID_W  MSHR readback fields, valid cycle after ack
mshr_src_id_i  in  SID_W  "
mshr_cache_set_i  in  SET_W  "
mshr_cache_way_i  in  WAY_W  "
mshr_cache_tag_i  in  TAG_W  "
mshr_word_i  in  WORD_W  "
mshr_need_rsp_i  in  1  "
refill_valid_o  out  1  line write request
refill_ready_i  in  1  line write accepted
refill_set_o  out  SET_W  target set
refill_way_o  out  WAY_W  target (victim) way
refill_tag_o  out  TAG_W  tag to install
refill_data_o  out  LINE_W  line, flit k at bits [k*MEM_DATA_W +: MEM_DATA_W]
core_rsp_valid_o  out  1  core response valid
core_rsp_ready_i  in  1  core response accepted
core_rsp_tid_o  out  TID_W  transaction id
core_rsp_sid_o  out  SID_W  source id
core_rsp_data_o  out  MEM_DATA_W  requested word
core_rsp_error_o  out  1  refill failed
busy_o  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, RECV, ACK_REQ, ACK_RD, WRITE, RSP. Reset: state IDLE, flit count 0, error flag 0, line buffer 0.
- Output reset values: all valids/ack/req low, busy_o 0, data outputs 0. mem_rsp_ready_o is 1 in IDLE/RECV, so it reads 1 right after reset.
- IDLE: on valid&ready, capture id, write flit into slot 0, cnt=1, err=mem_rsp_error_i. Go to ACK_REQ if last, else RECV.
- RECV: each accepted flit goes to slot cnt; cnt++. A flit with cnt==FLITS is dropped and sets err (overrun). On last, go to ACK_REQ; if total flits != FLITS, set err (short line). err ORs mem_rsp_error_i of every flit.
- ACK_REQ: ack_req_o=1. mshr_ack_o and mshr_ack_cs_o = ack_gnt_i, combinational, single cycle; set/way come from the captured id. On grant, go to ACK_RD.
- ACK_RD: register all mshr_*_i fields.
  - err=0: go to WRITE.
  - err=1 and need_rsp=1: go to RSP.
  - err=1 and need_rsp=0: go to IDLE.
- WRITE: refill_valid_o held with stable payload until refill_ready_i. Then go to RSP if need_rsp, else IDLE.
- RSP: core_rsp_valid_o held until core_rsp_ready_i, then go to IDLE.
  - core_rsp_data_o = line slot mshr_word (0 if err); core_rsp_error_o = err.
- Latency with no backpressure, 8-flit line, grant immediate:
  - last flit at T → ack at T+1, fields latched T+2, refill_valid T+3, core_rsp_valid T+4.
- One refill in flight at a time; mem_rsp_ready_o=0 in ACK_REQ..RSP.
- Reset mid-operation: discard line buffer, no ack issued, return to IDLE next cycle.

Optional Feature:
- Macro HPDCACHE_REFILL_PERF_EN.
- Defined:
  - adds outputs perf_refill_cnt_o[31:0] (increments on each WRITE handshake) and perf_err_cnt_o[31:0] (increments on each ACK_RD with err=1).
  - both counters wrap at 2^32 and clear on rst_i.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then id={1,2}, 8 flits 0x10..0x17, word=3, need_rsp=1, all readies 1 → mshr_ack_o at T+1 (set 2, way 1); refill_data_o flit3=0x13; core_rsp_data_o=0x13 at T+4.
- Prefetch-style refill, need_rsp=0 → refill handshake, then IDLE; core_rsp_valid_o never asserted; busy_o falls the cycle after refill handshake.
- ack_gnt_i held 0 for 5 cycles → ack_req_o stays 1, mshr_ack_o 0, mem_rsp_ready_o 0; ack fires on the first grant cycle.
- mem_rsp_error_i on flit 4, need_rsp=1 → no refill_valid_o; core_rsp_error_o=1, data 0.
- Short line (last on flit 5) or 9th flit → err=1, same error path; with PERF_EN, perf_err_cnt_o=1.
- rst_i asserted while in RECV after 4 flits → IDLE next cycle; a following clean 8-flit refill produces correct data with no stale flits.
